// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores to the data memory and registers MEM/WB results.
// Latency: a zero-wait access (ack in the request cycle) completes at the next edge; otherwise one extra cycle per wait state.
// Backpressure: stall is high while an access waits for dmem_ack; the upstream stage holds its inputs and the WB registers hold.
// Ports:
//   clock, reset_n                          - clock, async active-low reset
//   in_valid, result, result_2              - EX/MEM instruction, address/result, store data
//   load_inst, store_inst, ls_size, ls_unsigned, dest_reg, dest_reg_valid - op decode and writeback target
//   dmem_req/wr/addr/be/wdata, dmem_ack/rdata - data memory request / completion
//   wb_result, wb_dest_reg, wb_dest_reg_valid - registered MEM/WB values (forwarding source)
//   stall, misaligned, bus_error            - pipeline stall and one-cycle error pulses
module mem_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] result,
  input  logic [31:0] result_2,
  input  logic        load_inst,
  input  logic        store_inst,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [4:0]  dest_reg,
  input  logic        dest_reg_valid,
  output logic        dmem_req,
  output logic        dmem_wr,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_dest_reg,
  output logic        wb_dest_reg_valid,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error
);

  // Counter only has to reach MAX_WAIT-1 (the last WAIT cycle).
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   wb_result_q, wb_result_d;
  logic [4:0]    wb_dest_reg_q;
  logic          wb_valid_q, wb_valid_d;
  logic          misaligned_q, misaligned_d;
  logic          bus_error_q, bus_error_d;

  logic        is_half, is_word, mem_op, mis, timeout;
  logic        req_c, stall_c, done;
  logic [31:0] sh, load_data;

  assign is_half = (ls_size == 2'b01);
  assign is_word = ls_size[1];          // 11 (reserved) behaves as word
  assign mem_op  = in_valid & (load_inst | store_inst);
  assign mis     = (is_half & result[0]) | (is_word & (|result[1:0]));
  assign timeout = (state_q == S_WAIT) && (cnt_q == CNT_LAST);

  // Request fields come straight from the held EX/MEM inputs, so they stay
  // stable across WAIT without extra registers.
  assign dmem_addr = {result[31:2], 2'b00};
  assign dmem_wr   = store_inst;        // load+store together is a store

  always_comb begin
    case (ls_size)
      2'b00:   dmem_be = 4'b0001 << result[1:0];
      2'b01:   dmem_be = 4'b0011 << result[1:0];
      default: dmem_be = 4'b1111;
    endcase
  end

  always_comb begin
    case (ls_size)
      2'b00:   dmem_wdata = {4{result_2[7:0]}};
      2'b01:   dmem_wdata = {2{result_2[15:0]}};
      default: dmem_wdata = result_2;
    endcase
  end

  assign sh = dmem_rdata >> {result[1:0], 3'b000};

  always_comb begin
    case (ls_size)
      2'b00:   load_data = {{24{~ls_unsigned & sh[7]}}, sh[7:0]};
      2'b01:   load_data = {{16{~ls_unsigned & sh[15]}}, sh[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_c        = 1'b0;
    stall_c      = 1'b0;
    done         = 1'b0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // An ack with no request outstanding falls through untouched.
        if (mem_op) begin
          if (mis) begin
            misaligned_d = 1'b1;
          end else begin
            req_c = 1'b1;
            if (dmem_ack) begin
              done = 1'b1;
            end else begin
              stall_c = 1'b1;
              state_d = S_WAIT;
              cnt_d   = '0;
            end
          end
        end
      end
      S_WAIT: begin
        // The last permitted WAIT cycle abandons the access; a late ack
        // in that cycle is ignored because the request has been dropped.
        if (timeout) begin
          bus_error_d = 1'b1;
          state_d     = S_IDLE;
          cnt_d       = '0;
        end else begin
          req_c = 1'b1;
          if (dmem_ack) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            stall_c = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // WB next values (loaded only on non-stalled edges)
  always_comb begin
    wb_result_d = result;
    wb_valid_d  = 1'b0;
    if (done) begin
      if (!store_inst) wb_result_d = load_data;
      wb_valid_d = dest_reg_valid & ~store_inst;
    end else if ((state_q == S_IDLE) && in_valid && !mem_op) begin
      wb_valid_d = dest_reg_valid;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wb_result_q   <= '0;
      wb_dest_reg_q <= '0;
      wb_valid_q    <= 1'b0;
      misaligned_q  <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
      if (!stall_c) begin
        wb_result_q   <= wb_result_d;
        wb_dest_reg_q <= dest_reg;
        wb_valid_q    <= wb_valid_d;
      end
    end
  end

  // Gate with reset so an in-flight access drops the instant reset asserts.
  assign dmem_req          = req_c & reset_n;
  assign stall             = stall_c & reset_n;
  assign wb_result         = wb_result_q;
  assign wb_dest_reg       = wb_dest_reg_q;
  assign wb_dest_reg_valid = wb_valid_q;
  assign misaligned        = misaligned_q;
  assign bus_error         = bus_error_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (MAX_WAIT=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled after settling.
// Summary line reports total checks and errors.
module tb_mem_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] result;
  logic [31:0] result_2;
  logic        load_inst;
  logic        store_inst;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [4:0]  dest_reg;
  logic        dest_reg_valid;
  logic        dmem_req;
  logic        dmem_wr;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_result;
  logic [4:0]  wb_dest_reg;
  logic        wb_dest_reg_valid;
  logic        stall;
  logic        misaligned;
  logic        bus_error;

  int checks = 0;
  int errors = 0;
  int n;

  mem_stage #(.MAX_WAIT(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
    .result(result), .result_2(result_2),
    .load_inst(load_inst), .store_inst(store_inst),
    .ls_size(ls_size), .ls_unsigned(ls_unsigned),
    .dest_reg(dest_reg), .dest_reg_valid(dest_reg_valid),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_result(wb_result), .wb_dest_reg(wb_dest_reg),
    .wb_dest_reg_valid(wb_dest_reg_valid),
    .stall(stall), .misaligned(misaligned), .bus_error(bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                    input logic [31:0] res, input logic [31:0] r2,
                    input logic [4:0] dst, input logic dv);
    in_valid       = 1'b1;
    load_inst      = ld;
    store_inst     = st;
    ls_size        = sz;
    ls_unsigned    = uns;
    result         = res;
    result_2       = r2;
    dest_reg       = dst;
    dest_reg_valid = dv;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; result = '0; result_2 = '0;
    load_inst = 1'b0; store_inst = 1'b0; ls_size = 2'b00; ls_unsigned = 1'b0;
    dest_reg = '0; dest_reg_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;

    // Reset state
    #3;
    chk("rst_wb_result", wb_result, 32'h0);
    chk("rst_wb_valid", {31'b0, wb_dest_reg_valid}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_req", {31'b0, dmem_req}, 32'h0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
    chk("rst_bus_error", {31'b0, bus_error}, 32'h0);
    #9 reset_n = 1'b1;
    tick();

    // Non-memory op passes straight through
    op(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
    #1;
    chk("alu_stall", {31'b0, stall}, 32'h0);
    chk("alu_req", {31'b0, dmem_req}, 32'h0);
    tick();
    chk("alu_wb_result", wb_result, 32'h1234_5678);
    chk("alu_wb_dest", {27'b0, wb_dest_reg}, 32'd5);
    chk("alu_wb_valid", {31'b0, wb_dest_reg_valid}, 32'h1);

    // Load word at 0x100, ack in the third request cycle
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd3, 1'b1);
    #1;
    chk("lw_req", {31'b0, dmem_req}, 32'h1);
    chk("lw_addr", dmem_addr, 32'h0000_0100);
    chk("lw_be", {28'b0, dmem_be}, 32'hF);
    chk("lw_wr", {31'b0, dmem_wr}, 32'h0);
    chk("lw_stall0", {31'b0, stall}, 32'h1);
    tick();
    chk("lw_stall1", {31'b0, stall}, 32'h1);
    chk("lw_req_held", {31'b0, dmem_req}, 32'h1);
    chk("lw_wb_hold", wb_result, 32'h1234_5678);
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw_stall_ack", {31'b0, stall}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    chk("lw_wb_result", wb_result, 32'hDEAD_BEEF);
    chk("lw_wb_dest", {27'b0, wb_dest_reg}, 32'd3);
    chk("lw_wb_valid", {31'b0, wb_dest_reg_valid}, 32'h1);

    // Signed / unsigned byte loads at 0x103, zero-wait
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd4, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'h8012_3456;
    #1;
    chk("lb_stall", {31'b0, stall}, 32'h0);
    chk("lb_be", {28'b0, dmem_be}, 32'h8);
    tick();
    chk("lb_signed", wb_result, 32'hFFFF_FF80);
    ls_unsigned = 1'b1;
    tick();
    chk("lbu_unsigned", wb_result, 32'h0000_0080);
    dmem_ack = 1'b0;

    // Store half at 0x202, one wait state
    op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd7, 1'b1);
    #1;
    chk("sh_addr", dmem_addr, 32'h0000_0200);
    chk("sh_be", {28'b0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_wr", {31'b0, dmem_wr}, 32'h1);
    chk("sh_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("sh_wb_hold", wb_result, 32'h0000_0080);
    dmem_ack = 1'b1;
    #1;
    chk("sh_stall_ack", {31'b0, stall}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    chk("sh_wb_valid", {31'b0, wb_dest_reg_valid}, 32'h0);

    // Signed half load at 0x102, zero-wait
    op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 5'd9, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_0000;
    #1;
    chk("lh_be", {28'b0, dmem_be}, 32'hC);
    tick();
    chk("lh_signed", wb_result, 32'hFFFF_8001);
    chk("lh_wb_valid", {31'b0, wb_dest_reg_valid}, 32'h1);

    // Load and store together behaves as a byte store at 0x001
    op(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_005A, 5'd9, 1'b1);
    #1;
    chk("ls_wr", {31'b0, dmem_wr}, 32'h1);
    chk("ls_be", {28'b0, dmem_be}, 32'h2);
    chk("ls_wdata", dmem_wdata, 32'h5A5A_5A5A);
    tick();
    dmem_ack = 1'b0;
    chk("ls_wb_valid", {31'b0, wb_dest_reg_valid}, 32'h0);

    // Stray ack with nothing outstanding; bubble clears wb valid
    op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0055, 32'h0, 5'd1, 1'b1);
    tick();
    chk("pre_bubble_valid", {31'b0, wb_dest_reg_valid}, 32'h1);
    in_valid = 1'b0; dmem_ack = 1'b1;
    #1;
    chk("stray_req", {31'b0, dmem_req}, 32'h0);
    chk("stray_stall", {31'b0, stall}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    chk("bubble_valid", {31'b0, wb_dest_reg_valid}, 32'h0);

    // Misaligned word load at 0x101
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd2, 1'b1);
    #1;
    chk("mis_req", {31'b0, dmem_req}, 32'h0);
    chk("mis_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("mis_flag", {31'b0, misaligned}, 32'h1);
    chk("mis_wb_valid", {31'b0, wb_dest_reg_valid}, 32'h0);
    in_valid = 1'b0;
    tick();
    chk("mis_flag_clear", {31'b0, misaligned}, 32'h0);

    // Timeout: no ack, MAX_WAIT=4
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 5'd6, 1'b1);
    #1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (stall !== 1'b1) break;
      n++;
      tick();
    end
    chk("to_stall_cycles", n, 32'd4);
    chk("to_req_drop", {31'b0, dmem_req}, 32'h0);
    in_valid = 1'b0;
    tick();
    chk("to_bus_error", {31'b0, bus_error}, 32'h1);
    chk("to_wb_valid", {31'b0, wb_dest_reg_valid}, 32'h0);
    tick();
    chk("to_bus_error_clear", {31'b0, bus_error}, 32'h0);

    // Reset asserted in the middle of WAIT
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 5'd8, 1'b1);
    tick();
    tick();
    chk("rw_stall_before", {31'b0, stall}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rw_req", {31'b0, dmem_req}, 32'h0);
    chk("rw_stall", {31'b0, stall}, 32'h0);
    chk("rw_wb_result", wb_result, 32'h0);
    in_valid = 1'b0;
    #3 reset_n = 1'b1;
    tick();
    chk("rw_idle_req", {31'b0, dmem_req}, 32'h0);
    chk("rw_idle_stall", {31'b0, stall}, 32'h0);

    // Recovery: zero-wait load word after reset
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 5'd11, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
    #1;
    chk("rec_req", {31'b0, dmem_req}, 32'h1);
    tick();
    dmem_ack = 1'b0; in_valid = 1'b0;
    chk("rec_wb_result", wb_result, 32'h1122_3344);
    chk("rec_wb_valid", {31'b0, wb_dest_reg_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: the maximum number of cycles spent in WAIT before the access is abandoned.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: an instruction is present at the EX/MEM boundary.
REQ-005 SHALL have port result, input, 32 bits: the EX result, which is the effective address for loads and stores.
REQ-006 SHALL have port result_2, input, 32 bits: the forwarded store data.
REQ-007 SHALL have ports load_inst and store_inst, input, 1 bit each: the memory operation type.
REQ-008 SHALL have port ls_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-009 SHALL have port ls_unsigned, input, 1 bit: zero-extend load data when 1, sign-extend when 0.
REQ-010 SHALL have ports dest_reg (input, 5 bits) and dest_reg_valid (input, 1 bit): the writeback target.
REQ-011 SHALL have ports dmem_req (output, 1), dmem_wr (output, 1), dmem_addr (output, 32, word-aligned), dmem_be (output, 4), dmem_wdata (output, 32): the memory request.
REQ-012 SHALL have ports dmem_ack (input, 1) and dmem_rdata (input, 32): the memory completion; dmem_rdata is valid with dmem_ack.
REQ-013 SHALL have ports wb_result (output, 32), wb_dest_reg (output, 5), wb_dest_reg_valid (output, 1): the registered MEM/WB values, also the result_from_mem_wb forwarding source.
REQ-014 SHALL have ports stall (output, 1), misaligned (output, 1), bus_error (output, 1).

Function
REQ-015 SHALL implement a two-state FSM, IDLE and WAIT.
REQ-016 A memory op is in_valid & (load_inst | store_inst); a non-memory op SHALL pass result through to wb_result at the next edge with stall=0.
REQ-017 Misalignment SHALL be defined as half with result[0]=1, or word with result[1:0]!=0; on misalignment dmem_req=0, misaligned=1 registered for one cycle, and wb_dest_reg_valid=0.
REQ-018 In IDLE, an aligned memory op SHALL assert dmem_req combinationally, with dmem_addr={result[31:2],2'b00} and dmem_wr=store_inst.
REQ-019 Byte-enable lanes (little-endian) SHALL be: byte = 0001<<result[1:0]; half = 0011<<result[1:0]; word = 1111.
REQ-020 Store data lanes SHALL be: byte = {4{result_2[7:0]}}; half = {2{result_2[15:0]}}; word = result_2.
REQ-021 An ack in the same IDLE cycle (zero-wait access) SHALL complete the access: stall=0, WB registers load, FSM stays in IDLE.
REQ-022 Without ack in IDLE, the FSM SHALL go to WAIT with stall=1; dmem_req, dmem_addr, dmem_be, dmem_wdata and dmem_wr SHALL be held stable, and upstream holds its inputs.
REQ-023 In WAIT, ack SHALL cause stall=0 in that same cycle, load the WB registers at the edge, and return the FSM to IDLE.
REQ-024 The wait counter SHALL clear on entering WAIT and increment each WAIT cycle; when it reaches MAX_WAIT without ack: dmem_req drops, bus_error pulses 1 cycle (registered), wb_dest_reg_valid=0, stall=0, FSM goes to IDLE.
REQ-025 Load data SHALL be formed as sh = dmem_rdata >> (8*result[1:0]); byte = ext(sh[7:0]), half = ext(sh[15:0]), word = dmem_rdata; ext is zero when ls_unsigned=1, sign otherwise.
REQ-026 On completion, wb_dest_reg_valid SHALL equal dest_reg_valid & ~store_inst.
REQ-027 The WB registers SHALL update only on edges where stall=0; while stalled they hold.
REQ-028 When in_valid=0 and stall=0, wb_dest_reg_valid SHALL be 0 at the next edge.
REQ-029 Both load_inst and store_inst asserted SHALL be treated as a store.
REQ-030 An ack arriving while in IDLE with no request outstanding SHALL be ignored.

Reset
REQ-031 Reset SHALL force: FSM=IDLE, counter=0, and wb_result, wb_dest_reg, wb_dest_reg_valid, misaligned, bus_error = 0; dmem_req=0 and stall=0 immediately, including mid-WAIT; any in-flight access is abandoned.

Verification
REQ-032 Load word, result=0x100, 2-cycle ack, rdata=0xDEADBEEF -> stall=1 for 2 cycles, dmem_be=1111, then wb_result=0xDEADBEEF with wb_dest_reg_valid=1.
REQ-033 Signed byte load at 0x103, rdata=0x80123456, zero-wait ack -> wb_result=0xFFFFFF80, stall=0; the same access with ls_unsigned=1 -> 0x00000080.
REQ-034 Store half at 0x202, result_2=0x0000ABCD -> dmem_addr=0x200, be=1100, wdata=0xABCDABCD, dmem_wr=1, wb_dest_reg_valid=0.
REQ-035 Load word at 0x101 -> no dmem_req, misaligned=1 for one cycle, wb_dest_reg_valid=0.
REQ-036 MAX_WAIT=4, no ack -> stall for 4 cycles, bus_error pulses, dmem_req drops; reset_n asserted during a separate WAIT -> dmem_req=0 and stall=0 immediately.
